// File: rtl/c_calc_seq.sv
// c_calc_seq: keypad-to-ALU sequencer for the 8-bit calculator.
// Optional feature macro: CALC_SEQ_REPEAT_EQ_EN (equal without new digits repeats the last operation).
module c_calc_seq #(
   parameter int PULSE_W    = 1,
   parameter int GAP_W      = 1,
   parameter int MAX_DIGITS = 3
) (
   input  logic       i_sys_clock,
   input  logic       i_sys_reset_n,
   input  logic       i_c_key_valid,
   input  logic [1:0] i_c_key_class,
   input  logic [3:0] i_c_key_value,
   output logic       o_c_key_ready,
   input  logic       i_c_alu_overflow_flag,
   output logic       o_c_alu_clear,
   output logic       o_c_alu_en,
   output logic       o_c_alu_equal,
   output logic [3:0] o_c_alu_op_keycode,
   output logic [8:0] o_c_alu_operand,
   output logic [8:0] o_c_entry,
   output logic       o_c_disp_sel,
   output logic       o_c_error
);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_INV = 4'b0100;
   localparam logic [3:0] OP_IDLE = 4'b1111;
   localparam int DW = $clog2(MAX_DIGITS + 1);
   typedef enum logic [2:0] {CLR, ENTRY, SETUP, STROBE, RELEASE, CHECK, ERROR} state_t;
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d, mag_q, mag_d;
   logic sign_q, sign_d, use_eq_q, use_eq_d, eq_flag_q, eq_flag_d, disp_q, disp_d, load_q, load_d;
   logic [DW-1:0] dig_q, dig_d;
   logic [3:0] pend_q, pend_d, sop_q, sop_d, load_val_q, load_val_d;
   logic [8:0] opnd_q, opnd_d, entry_val;
   logic [11:0] next_mag;
   logic accept, go, go_eq;
   logic [3:0] go_op;
   logic [8:0] go_opnd;
`ifdef CALC_SEQ_REPEAT_EQ_EN
   logic [3:0] last_op_q, last_op_d;
   logic [8:0] last_opnd_q, last_opnd_d;
`endif
   // a zero magnitude is never presented with a negative sign
   assign entry_val = (mag_q == 8'd0) ? 9'h000 : {sign_q, mag_q};
   assign next_mag = {4'b0, mag_q} * 12'd10 + {8'b0, i_c_key_value};
   assign accept = i_c_key_valid & o_c_key_ready;
   assign o_c_key_ready = (state_q == ENTRY) || (state_q == ERROR);
   assign o_c_alu_clear = (state_q == CLR);
   assign o_c_alu_en = (state_q == STROBE) && !use_eq_q;
   assign o_c_alu_equal = (state_q == STROBE) && use_eq_q;
   assign o_c_alu_op_keycode = (state_q == SETUP || state_q == STROBE) ? sop_q : OP_IDLE;
   assign o_c_alu_operand = (state_q == SETUP || state_q == STROBE || state_q == RELEASE) ? opnd_q : entry_val;
   assign o_c_entry = entry_val;
   assign o_c_disp_sel = disp_q;
   assign o_c_error = (state_q == ERROR);
   // next-state: key decode in ENTRY, timed strobe sequence, overflow check
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      mag_d = mag_q;
      sign_d = sign_q;
      dig_d = dig_q;
      pend_d = pend_q;
      sop_d = sop_q;
      opnd_d = opnd_q;
      use_eq_d = use_eq_q;
      eq_flag_d = eq_flag_q;
      disp_d = disp_q;
      load_d = load_q;
      load_val_d = load_val_q;
      go = 1'b0;
      go_eq = 1'b0;
      go_op = pend_q;
      go_opnd = entry_val;
`ifdef CALC_SEQ_REPEAT_EQ_EN
      last_op_d = last_op_q;
      last_opnd_d = last_opnd_q;
`endif
      case (state_q)
         CLR: begin
            mag_d = load_q ? {4'b0, load_val_q} : 8'd0;
            dig_d = load_q ? DW'(1) : '0;
            sign_d = 1'b0;
            pend_d = OP_ADD;
            eq_flag_d = 1'b0;
            disp_d = 1'b0;
            load_d = 1'b0;
            state_d = ENTRY;
         end
         ENTRY: if (accept) begin
            case (i_c_key_class)
               2'b00: if (eq_flag_q) begin
                  load_d = 1'b1;
                  load_val_d = i_c_key_value;
                  state_d = CLR;
               end else begin
                  disp_d = 1'b0;
                  if (int'(dig_q) < MAX_DIGITS && next_mag <= 12'd255) begin
                     mag_d = next_mag[7:0];
                     dig_d = dig_q + 1'b1;
                  end
               end
               2'b01: if (i_c_key_value == OP_INV) begin
                  go = 1'b1;
                  go_eq = 1'b1;
                  go_op = OP_INV;
               end else if (i_c_key_value != OP_IDLE) begin
                  eq_flag_d = 1'b0;
                  pend_d = i_c_key_value;
                  if (dig_q != '0) begin
                     go = 1'b1;
                     mag_d = 8'd0;
                     sign_d = 1'b0;
                     dig_d = '0;
                  end
               end
               2'b10: if (dig_q != '0) begin
                  go = 1'b1;
                  go_eq = 1'b1;
                  pend_d = OP_ADD;
                  eq_flag_d = 1'b1;
                  mag_d = 8'd0;
                  sign_d = 1'b0;
                  dig_d = '0;
`ifdef CALC_SEQ_REPEAT_EQ_EN
                  last_op_d = pend_q;
                  last_opnd_d = entry_val;
               end else if (eq_flag_q) begin
                  go = 1'b1;
                  go_eq = 1'b1;
                  go_op = last_op_q;
                  go_opnd = last_opnd_q;
`endif
               end
               default: begin
                  if (i_c_key_value == 4'd0) state_d = CLR;
                  else if (i_c_key_value == 4'd1) sign_d = ~sign_q;
               end
            endcase
            if (go) begin
               state_d = SETUP;
               use_eq_d = go_eq;
               sop_d = go_op;
               opnd_d = go_opnd;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d = 8'd0;
         end
         STROBE: begin
            cnt_d = (cnt_q == 8'(PULSE_W - 1)) ? 8'd0 : cnt_q + 8'd1;
            if (cnt_q == 8'(PULSE_W - 1)) state_d = RELEASE;
         end
         RELEASE: begin
            cnt_d = (cnt_q == 8'(GAP_W - 1)) ? 8'd0 : cnt_q + 8'd1;
            if (cnt_q == 8'(GAP_W - 1)) begin
               state_d = CHECK;
               disp_d = 1'b1;
            end
         end
         CHECK: state_d = i_c_alu_overflow_flag ? ERROR : ENTRY;
         ERROR: if (accept && i_c_key_class == 2'b11 && i_c_key_value == 4'd0) state_d = CLR;
         default: state_d = CLR;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
      if (!i_sys_reset_n) begin
         state_q <= CLR;
         cnt_q <= 8'd0;
         mag_q <= 8'd0;
         sign_q <= 1'b0;
         dig_q <= '0;
         pend_q <= OP_ADD;
         sop_q <= OP_IDLE;
         opnd_q <= 9'h000;
         use_eq_q <= 1'b0;
         eq_flag_q <= 1'b0;
         disp_q <= 1'b0;
         load_q <= 1'b0;
         load_val_q <= 4'd0;
`ifdef CALC_SEQ_REPEAT_EQ_EN
         last_op_q <= OP_ADD;
         last_opnd_q <= 9'h000;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         mag_q <= mag_d;
         sign_q <= sign_d;
         dig_q <= dig_d;
         pend_q <= pend_d;
         sop_q <= sop_d;
         opnd_q <= opnd_d;
         use_eq_q <= use_eq_d;
         eq_flag_q <= eq_flag_d;
         disp_q <= disp_d;
         load_q <= load_d;
         load_val_q <= load_val_d;
`ifdef CALC_SEQ_REPEAT_EQ_EN
         last_op_q <= last_op_d;
         last_opnd_q <= last_opnd_d;
`endif
      end
   end
endmodule

// File: tb/tb_c_calc_seq.sv
// tb_c_calc_seq: directed bench for c_calc_seq with a small behavioural ALU.
module tb_c_calc_seq;
   localparam logic [1:0] DIG = 2'b00, OPR = 2'b01, EQU = 2'b10, CMD = 2'b11;
   logic clk = 1'b0, rst_n;
   logic k_valid, k_ready, ovf, alu_clr, en, eq, disp, err;
   logic [1:0] k_cls;
   logic [3:0] k_val, kc;
   logic [8:0] opnd, entry;
   logic k2_valid, k2_ready, ovf2, alu_clr2, en2, eq2, disp2, err2;
   logic [1:0] k2_cls;
   logic [3:0] k2_val, kc2;
   logic [8:0] opnd2, entry2;
   int checks = 0, errors = 0;
   int acc, en_cnt, eq_cnt, en2_hi, both, both2;
   logic pen, peq;
   logic [3:0] last_en_op, last_eq_op;
   logic [8:0] last_en_opnd, last_eq_opnd;
   int e0, q0, lo;

   always #5 clk = ~clk;

   c_calc_seq dut (
      .i_sys_clock(clk), .i_sys_reset_n(rst_n),
      .i_c_key_valid(k_valid), .i_c_key_class(k_cls), .i_c_key_value(k_val), .o_c_key_ready(k_ready),
      .i_c_alu_overflow_flag(ovf), .o_c_alu_clear(alu_clr), .o_c_alu_en(en), .o_c_alu_equal(eq),
      .o_c_alu_op_keycode(kc), .o_c_alu_operand(opnd), .o_c_entry(entry), .o_c_disp_sel(disp), .o_c_error(err)
   );

   c_calc_seq #(.PULSE_W(3), .GAP_W(2)) dut2 (
      .i_sys_clock(clk), .i_sys_reset_n(rst_n),
      .i_c_key_valid(k2_valid), .i_c_key_class(k2_cls), .i_c_key_value(k2_val), .o_c_key_ready(k2_ready),
      .i_c_alu_overflow_flag(ovf2), .o_c_alu_clear(alu_clr2), .o_c_alu_en(en2), .o_c_alu_equal(eq2),
      .o_c_alu_op_keycode(kc2), .o_c_alu_operand(opnd2), .o_c_entry(entry2), .o_c_disp_sel(disp2), .o_c_error(err2)
   );

   function automatic int calc(input int a, input logic [3:0] k, input logic [8:0] o);
      int b;
      b = o[8] ? -int'(o[7:0]) : int'(o[7:0]);
      case (k)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a * b;
         4'd4: return -a;
         default: return a;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 0; ovf <= 1'b0; pen <= 1'b0; peq <= 1'b0;
         en_cnt <= 0; eq_cnt <= 0;
      end else begin
         pen <= en;
         peq <= eq;
         if (alu_clr) begin
            acc <= 0; ovf <= 1'b0;
         end else if ((en && !pen) || (eq && !peq)) begin
            acc <= calc(acc, kc, opnd);
            ovf <= ovf || (calc(acc, kc, opnd) > 255) || (calc(acc, kc, opnd) < -255);
            if (en) begin en_cnt <= en_cnt + 1; last_en_op <= kc; last_en_opnd <= opnd; end
            else begin eq_cnt <= eq_cnt + 1; last_eq_op <= kc; last_eq_opnd <= opnd; end
         end
      end
   end

   initial begin en2_hi = 0; both = 0; both2 = 0; end
   always @(negedge clk) begin
      if (en2) en2_hi++;
      if (en2 && eq2) both2++;
      if (en && eq) both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [1:0] c, input logic [3:0] v);
      int n;
      n = 0;
      k_cls = c; k_val = v; k_valid = 1'b1;
      while (!k_ready && n < 100) begin @(negedge clk); n++; end
      if (!k_ready) check("press_timeout", k_ready, 1);
      else @(posedge clk);
      #1 k_valid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!k_ready && n < 100) begin @(negedge clk); n++; end
      if (!k_ready) check("idle_timeout", k_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; ovf2 = 1'b0;
      k_valid = 1'b0; k_cls = 2'b00; k_val = 4'd0;
      k2_valid = 1'b0; k2_cls = 2'b00; k2_val = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_alu_clear", alu_clr, 1);
      check("rst_strobes", {en, eq}, 0);
      check("rst_keycode", kc, 4'hF);
      check("rst_operand", opnd, 0);
      check("rst_entry", entry, 0);
      check("rst_disp_err", {disp, err}, 0);
      check("rst_ready", k_ready, 0);
      rst_n = 1'b1;
      #1 check("clr_first_cycle", alu_clr, 1);
      @(negedge clk);
      check("clr_done", {alu_clr, k_ready}, 2'b01);
      // 12 + 5 = 17
      press(DIG, 4'd1); press(DIG, 4'd2);
      check("entry_12", entry, 9'h00C);
      press(OPR, 4'd0);
      check("en_count", en_cnt, 1);
      check("en_operand", last_en_opnd, 9'h00C);
      check("en_keycode", last_en_op, 4'h0);
      check("entry_after_op", entry, 0);
      check("disp_after_strobe", disp, 1);
      press(DIG, 4'd5);
      check("entry_5_disp", {disp, entry}, {1'b0, 9'h005});
      press(EQU, 4'd0);
      check("eq_operand", last_eq_opnd, 9'h005);
      check("eq_keycode", last_eq_op, 4'h0);
      check("result_17", acc, 17);
      check("no_error", err, 0);
      check("eq_count", eq_cnt, 1);
      // digit after equal starts a new chain
      press(DIG, 4'd2);
      check("new_chain_entry", entry, 2);
      check("new_chain_alu_cleared", acc, 0);
      press(DIG, 4'd5); press(DIG, 4'd6);
      check("reject_256", entry, 25);
      press(CMD, 4'd0);
      press(DIG, 4'd9); press(DIG, 4'd9); press(DIG, 4'd9); press(DIG, 4'd9);
      check("reject_999", entry, 99);
      press(CMD, 4'd0);
      press(DIG, 4'd0); press(DIG, 4'd0); press(DIG, 4'd1); press(DIG, 4'd2);
      check("max_digits", entry, 1);
      // operator replaced without a strobe: 5 - 3 = 2
      press(CMD, 4'd0);
      press(DIG, 4'd5); press(OPR, 4'd0);
      e0 = en_cnt;
      press(OPR, 4'd1);
      check("no_strobe_on_replace", en_cnt, e0);
      press(DIG, 4'd3); press(EQU, 4'd0);
      check("result_2", acc, 2);
      // 5 - (-3) = 8
      press(CMD, 4'd0);
      press(DIG, 4'd5); press(OPR, 4'd0); press(OPR, 4'd1); press(DIG, 4'd3); press(CMD, 4'd1);
      check("neg_operand", opnd, 9'h103);
      press(EQU, 4'd0);
      check("neg_eq_operand", last_eq_opnd, 9'h103);
      check("result_8", acc, 8);
      // sign toggle on empty entry keeps operand zero
      press(CMD, 4'd0); press(CMD, 4'd1);
      check("neg_zero", opnd, 9'h000);
      // repeated equal
      press(CMD, 4'd0);
      press(DIG, 4'd4); press(OPR, 4'd0); press(DIG, 4'd1); press(EQU, 4'd0);
      check("result_5", acc, 5);
      press(EQU, 4'd0);
`ifdef CALC_SEQ_REPEAT_EQ_EN
      check("repeat_eq", acc, 6);
`else
      check("repeat_eq", acc, 5);
`endif
      // invert current result
      press(CMD, 4'd0);
      press(DIG, 4'd3); press(EQU, 4'd0);
      q0 = eq_cnt;
      press(OPR, 4'd4);
      check("invert_result", acc, -3);
      check("invert_keycode", last_eq_op, 4'h4);
      check("invert_eq_count", eq_cnt, q0 + 1);
      // overflow: 200 * 2
      press(CMD, 4'd0);
      press(DIG, 4'd2); press(DIG, 4'd0); press(DIG, 4'd0); press(OPR, 4'd2);
      press(DIG, 4'd2); press(EQU, 4'd0);
      check("overflow_error", err, 1);
      e0 = en_cnt;
      press(DIG, 4'd7); press(OPR, 4'd0);
      check("error_discard", {err, entry}, {1'b1, 9'h000});
      check("error_no_strobe", en_cnt, e0);
      k_cls = CMD; k_val = 4'd0; k_valid = 1'b1;
      @(posedge clk);
      #1 k_valid = 1'b0;
      @(negedge clk);
      check("clear_pulse", {alu_clr, err}, 2'b10);
      @(negedge clk);
      check("clear_one_cycle", {alu_clr, k_ready, err}, 3'b010);
      check("alu_reset", acc, 0);
      // strobe timing with PULSE_W=3, GAP_W=2
      @(negedge clk);
      k2_cls = DIG; k2_val = 4'd1; k2_valid = 1'b1;
      @(posedge clk);
      #1 k2_valid = 1'b0;
      @(negedge clk);
      k2_cls = OPR; k2_val = 4'd0; k2_valid = 1'b1;
      e0 = en2_hi;
      @(posedge clk);
      #1 k2_valid = 1'b0;
      @(negedge clk);
      check("setup_cycle", {en2, eq2, kc2}, 6'b000000);
      lo = 0;
      while (!k2_ready && lo < 50) begin lo++; @(negedge clk); end
      check("ready_low_cycles", lo, 7);
      check("en_high_cycles", en2_hi - e0, 3);
      check("never_both_w", both2, 0);
      check("never_both", both, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
